// File: rtl/io_ports.sv
// Memory-mapped GPIO block: N_PORTS 8-bit bidirectional ports with synchronised inputs,
// per-pin edge interrupt flags, atomic set/clear writes and a single level IRQ.
module io_ports #(
  parameter int unsigned N_PORTS   = 2,
  parameter logic [15:0] BASE_ADDR = 16'h8400
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bus_sel,
  input  logic                 bus_we,
  input  logic [15:0]          bus_addr,
  input  logic [7:0]           bus_wdata,
  output logic [7:0]           bus_rdata,
  output logic                 bus_hit,
  input  logic [8*N_PORTS-1:0] pin_in,
  output logic [8*N_PORTS-1:0] pin_out,
  output logic [8*N_PORTS-1:0] pin_oe,
  output logic                 irq
);

  localparam int unsigned W    = 8 * N_PORTS;
  localparam logic [15:0] SPAN = 16'(W);

  localparam logic [2:0] REG_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR   = 3'd1;
  localparam logic [2:0] REG_IN    = 3'd2;
  localparam logic [2:0] REG_IFLAG = 3'd3;
  localparam logic [2:0] REG_IMASK = 3'd4;
  localparam logic [2:0] REG_IEDGE = 3'd5;
  localparam logic [2:0] REG_SET   = 3'd6;
  localparam logic [2:0] REG_CLR   = 3'd7;

  // Address decode
  logic [15:0] w_offset;
  logic        w_hit;
  logic        w_wr;
  logic [2:0]  w_port;
  logic [2:0]  w_reg;

  assign w_offset = bus_addr - BASE_ADDR;
  assign w_hit    = bus_sel && (w_offset < SPAN);
  assign w_wr     = w_hit && bus_we;
  assign w_port   = w_offset[5:3];
  assign w_reg    = w_offset[2:0];

  // State
  logic [W-1:0] r_out;
  logic [W-1:0] r_dir;
  logic [W-1:0] r_iflag;
  logic [W-1:0] r_imask;
  logic [W-1:0] r_iedge;
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;
  logic [1:0]   r_warm;
  logic [7:0]   r_rdata;
  logic         r_hit;
  logic         r_irq;

  // Next-state
  logic [W-1:0] w_out_d;
  logic [W-1:0] w_dir_d;
  logic [W-1:0] w_imask_d;
  logic [W-1:0] w_iedge_d;
  logic [W-1:0] w_clr;
  logic [W-1:0] w_rise;
  logic [W-1:0] w_fall;
  logic [W-1:0] w_event;
  logic [W-1:0] w_iflag_d;
  logic [7:0]   w_rdata;

  always_comb begin
    w_out_d   = r_out;
    w_dir_d   = r_dir;
    w_imask_d = r_imask;
    w_iedge_d = r_iedge;
    w_clr     = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_wr && (w_port == 3'(p))) begin
        case (w_reg)
          REG_OUT:   w_out_d[8*p +: 8]   = bus_wdata;
          REG_DIR:   w_dir_d[8*p +: 8]   = bus_wdata;
          REG_IFLAG: w_clr[8*p +: 8]     = bus_wdata;
          REG_IMASK: w_imask_d[8*p +: 8] = bus_wdata;
          REG_IEDGE: w_iedge_d[8*p +: 8] = bus_wdata;
          REG_SET:   w_out_d[8*p +: 8]   = r_out[8*p +: 8] | bus_wdata;
          REG_CLR:   w_out_d[8*p +: 8]   = r_out[8*p +: 8] & ~bus_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_port == 3'(p)) begin
        case (w_reg)
          REG_OUT:   w_rdata = r_out[8*p +: 8];
          REG_DIR:   w_rdata = r_dir[8*p +: 8];
          REG_IN:    w_rdata = r_s2[8*p +: 8];
          REG_IFLAG: w_rdata = r_iflag[8*p +: 8];
          REG_IMASK: w_rdata = r_imask[8*p +: 8];
          REG_IEDGE: w_rdata = r_iedge[8*p +: 8];
          default:   w_rdata = 8'h00;
        endcase
      end
    end
  end

  // Edge detection; a new event beats a same-cycle W1C on the same bit.
  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_event   = (r_warm == 2'd3) ? ((r_iedge & w_rise) | (~r_iedge & w_fall)) : '0;
  assign w_iflag_d = (r_iflag & ~w_clr) | w_event;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_iflag <= '0;
      r_imask <= '0;
      r_iedge <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_warm  <= 2'd0;
      r_rdata <= 8'h00;
      r_hit   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_out   <= w_out_d;
      r_dir   <= w_dir_d;
      r_imask <= w_imask_d;
      r_iedge <= w_iedge_d;
      r_iflag <= w_iflag_d;
      r_s1    <= pin_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end
      if (bus_sel) begin
        r_hit <= w_hit;
      end
      if (w_hit && !bus_we) begin
        r_rdata <= w_rdata;
      end
      r_irq <= |(r_iflag & r_imask);
    end
  end

  assign pin_out   = r_out;
  assign pin_oe    = r_dir;
  assign bus_rdata = r_rdata;
  assign bus_hit   = r_hit;
  assign irq       = r_irq;

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: per-cycle comparison against a behavioural model
// built on a pin-sample history, plus directed vectors with literal expectations.
module tb_io_ports;

  localparam int unsigned NP = 2;
  localparam int unsigned W  = 8 * NP;
  localparam int unsigned HN = 4096;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b1;
  logic         bus_sel   = 1'b0;
  logic         bus_we    = 1'b0;
  logic [15:0]  bus_addr  = 16'h0000;
  logic [7:0]   bus_wdata = 8'h00;
  logic [7:0]   bus_rdata;
  logic         bus_hit;
  logic [W-1:0] pin_in    = '0;
  logic [W-1:0] pin_out;
  logic [W-1:0] pin_oe;
  logic         irq;

  int n_checks = 0;
  int n_errors = 0;

  io_ports #(
    .N_PORTS  (NP),
    .BASE_ADDR(16'h8400)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus_sel  (bus_sel),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_hit  (bus_hit),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .pin_oe   (pin_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers per port, pins remembered by edge number since reset.
  logic [7:0]   m_out   [NP];
  logic [7:0]   m_dir   [NP];
  logic [7:0]   m_iflag [NP];
  logic [7:0]   m_imask [NP];
  logic [7:0]   m_iedge [NP];
  logic [7:0]   m_rdata;
  logic         m_hit;
  logic         m_irq;
  int           m_n;
  logic [W-1:0] m_hist [HN];

  function automatic logic [W-1:0] hist(input int i);
    return (i < 1) ? '0 : m_hist[i % HN];
  endfunction

  function automatic logic [7:0] mread(input int p, input int r);
    logic [W-1:0] inv;
    inv = hist(m_n - 1);
    case (r)
      0:       return m_out[p];
      1:       return m_dir[p];
      2:       return inv[8*p +: 8];
      3:       return m_iflag[p];
      4:       return m_imask[p];
      5:       return m_iedge[p];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int           n;
    int           p;
    int           r;
    logic [15:0]  off;
    logic [W-1:0] nw;
    logic [W-1:0] od;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
    logic [7:0]   clr;
    logic [7:0]   ev;
    if (!reset_n) begin
      for (int i = 0; i < NP; i++) begin
        m_out[i]   <= 8'h00;
        m_dir[i]   <= 8'h00;
        m_iflag[i] <= 8'h00;
        m_imask[i] <= 8'h00;
        m_iedge[i] <= 8'h00;
      end
      m_rdata <= 8'h00;
      m_hit   <= 1'b0;
      m_irq   <= 1'b0;
      m_n     <= 0;
    end else begin
      n = m_n + 1;
      m_n <= n;
      m_hist[n % HN] <= pin_in;
      // A pin change sampled at edge k is acted on at edge k+2.
      nw   = hist(n - 2);
      od   = hist(n - 3);
      rise = nw & ~od;
      fall = ~nw & od;
      any  = 1'b0;
      for (int i = 0; i < NP; i++) any = any | (|(m_iflag[i] & m_imask[i]));
      m_irq <= any;
      p   = -1;
      r   = 0;
      clr = 8'h00;
      if (bus_sel) begin
        off = bus_addr - 16'h8400;
        if (int'(off) < 8 * NP) begin
          p = int'(off) / 8;
          r = int'(off) % 8;
          m_hit <= 1'b1;
          if (bus_we) begin
            case (r)
              0: m_out[p]   <= bus_wdata;
              1: m_dir[p]   <= bus_wdata;
              3: clr = bus_wdata;
              4: m_imask[p] <= bus_wdata;
              5: m_iedge[p] <= bus_wdata;
              6: m_out[p]   <= m_out[p] | bus_wdata;
              7: m_out[p]   <= m_out[p] & ~bus_wdata;
              default: ;
            endcase
          end else begin
            m_rdata <= mread(p, r);
          end
        end else begin
          m_hit <= 1'b0;
        end
      end
      for (int i = 0; i < NP; i++) begin
        ev = (n >= 4) ? ((m_iedge[i] & rise[8*i +: 8]) | (~m_iedge[i] & fall[8*i +: 8]))
                      : 8'h00;
        m_iflag[i] <= (m_iflag[i] & ~((i == p) ? clr : 8'h00)) | ev;
      end
    end
  end

  logic [W-1:0] m_out_flat;
  logic [W-1:0] m_dir_flat;
  always_comb begin
    m_out_flat = '0;
    m_dir_flat = '0;
    for (int i = 0; i < NP; i++) begin
      m_out_flat[8*i +: 8] = m_out[i];
      m_dir_flat[8*i +: 8] = m_dir[i];
    end
  end

  always @(negedge clk) begin
    chk("model pin_out", 32'(pin_out), 32'(m_out_flat));
    chk("model pin_oe", 32'(pin_oe), 32'(m_dir_flat));
    chk("model irq", 32'(irq), 32'(m_irq));
    chk("model bus_hit", 32'(bus_hit), 32'(m_hit));
    chk("model bus_rdata", 32'(bus_rdata), 32'(m_rdata));
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_sel   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(posedge clk);
    #2;
    bus_sel = 1'b0;
    bus_we  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus_sel  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = a;
    @(posedge clk);
    #2;
    d       = bus_rdata;
    bus_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] d;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #3 pin_in = 16'($urandom);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    idle(10);
    chk("reset pin_out", 32'(pin_out), 32'h0);
    chk("reset pin_oe", 32'(pin_oe), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    rd(16'h8403, d);
    chk("reset iflag p0", 32'(d), 32'h0);
    rd(16'h840B, d);
    chk("reset iflag p1", 32'(d), 32'h0);

    // Reset pulsed while a write to OUT is in flight
    pin_in = '0;
    wr(16'h8400, 8'h55);
    chk("pre-reset out", 32'(pin_out), 32'h0055);
    bus_sel   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 16'h8400;
    bus_wdata = 8'hFF;
    reset_n   = 1'b0;
    @(posedge clk);
    #2;
    bus_sel = 1'b0;
    bus_we  = 1'b0;
    reset_n = 1'b1;
    #1 chk("reset mid-write out", 32'(pin_out), 32'h0);
    idle(4);

    // Register map
    wr(16'h8400, 8'hA5);
    wr(16'h8401, 8'h0F);
    wr(16'h8408, 8'h3C);
    chk("map pin_out", 32'(pin_out), 32'h3CA5);
    chk("map pin_oe", 32'(pin_oe), 32'h000F);
    rd(16'h8400, d);
    chk("rd out0", 32'(d), 32'hA5);
    rd(16'h8401, d);
    chk("rd dir0", 32'(d), 32'h0F);
    rd(16'h8408, d);
    chk("rd out1", 32'(d), 32'h3C);
    chk("hit on read", 32'(bus_hit), 32'h1);
    rd(16'h8410, d);
    chk("miss hit", 32'(bus_hit), 32'h0);
    chk("miss rdata held", 32'(d), 32'h3C);
    wr(16'h8410, 8'hEE);
    chk("miss write no effect", 32'(pin_out), 32'h3CA5);
    rd(16'h83FF, d);
    chk("below base miss", 32'(bus_hit), 32'h0);
    wr(16'h8402, 8'h77);
    rd(16'h8402, d);
    chk("in ro", 32'(d), 32'h00);

    // Synchronised input readback on port 1
    pin_in[15:8] = 8'h5A;
    idle(3);
    rd(16'h840A, d);
    chk("in port1", 32'(d), 32'h5A);

    // Set / clear
    wr(16'h8400, 8'h00);
    wr(16'h8406, 8'h81);
    chk("out_set", 32'(pin_out[7:0]), 32'h81);
    wr(16'h8407, 8'h01);
    chk("out_clr", 32'(pin_out[7:0]), 32'h80);
    rd(16'h8406, d);
    chk("rd set reg", 32'(d), 32'h00);
    rd(16'h8407, d);
    chk("rd clr reg", 32'(d), 32'h00);

    // Rising edge interrupt on pin0
    wr(16'h8404, 8'h01);
    wr(16'h8405, 8'h01);
    pin_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 chk("irq k+2", 32'(irq), 32'h0);
    @(posedge clk);
    #1 chk("irq k+3", 32'(irq), 32'h1);
    #1;
    rd(16'h8403, d);
    chk("iflag rise", 32'(d), 32'h01);
    pin_in[0] = 1'b0;
    idle(5);
    rd(16'h8403, d);
    chk("fall no new flag", 32'(d), 32'h01);
    wr(16'h8403, 8'h01);
    chk("irq at w1c edge", 32'(irq), 32'h1);
    @(posedge clk);
    #1 chk("irq after w1c", 32'(irq), 32'h0);
    #1;

    // Collision: W1C sampled on the same edge as a new rising event
    pin_in[0] = 1'b1;
    idle(5);
    chk("irq re-raised", 32'(irq), 32'h1);
    pin_in[0] = 1'b0;
    idle(5);
    pin_in[0] = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    wr(16'h8403, 8'h01);
    chk("collision irq k+2", 32'(irq), 32'h1);
    @(posedge clk);
    #1 chk("collision irq k+3", 32'(irq), 32'h1);
    #1;
    rd(16'h8403, d);
    chk("collision iflag", 32'(d), 32'h01);

    // Masked flag on pin3 (falling edge, IEDGE bit3 = 0)
    wr(16'h8403, 8'hFF);
    wr(16'h8404, 8'h00);
    pin_in[3] = 1'b1;
    idle(4);
    pin_in[3] = 1'b0;
    idle(5);
    rd(16'h8403, d);
    chk("masked iflag", 32'(d), 32'h08);
    chk("masked irq", 32'(irq), 32'h0);
    wr(16'h8404, 8'h08);
    chk("unmask irq same edge", 32'(irq), 32'h0);
    @(posedge clk);
    #1 chk("unmask irq", 32'(irq), 32'h1);
    #1;

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_ports.md
# io_ports

Parametrised memory-mapped GPIO peripheral that replaces the single write-only 8-bit output latch on the CPU bus. It provides N_PORTS 8-bit bidirectional ports, each with output, direction, synchronised input, per-pin edge-triggered interrupt flags and atomic set/clear writes. It sits on the system clock, is accessed through a one-cycle bus strobe generated by the CPU bus logic, and drives a single level interrupt toward the CPU IRQ input.

## Interface
- N_PORTS, 2, number of 8-bit ports (legal 1..8)
- BASE_ADDR, 16'h8400, first register address; must be 64-byte aligned
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- bus_sel  in  1  one-cycle access strobe; bus fields are valid in this cycle
- bus_we  in  1  1 = write, 0 = read (sampled with bus_sel)
- bus_addr  in  16  CPU address
- bus_wdata  in  8  write data
- bus_rdata  out  8  registered read data
- bus_hit  out  1  registered; 1 if the previous strobed access decoded to this block
- pin_in  in  8*N_PORTS  asynchronous pin inputs, port p at [8p+7:8p]
- pin_out  out  8*N_PORTS  output register values
- pin_oe  out  8*N_PORTS  output enables (= DIR)
- irq  out  1  registered, level, active-high

## Operation
- Offset = bus_addr - BASE_ADDR. Hit when offset < 8*N_PORTS. Port p = offset[5:3], register r = offset[2:0].
- Per-port registers:
  - r0 OUT: RW.
  - r1 DIR: RW; 1 = output.
  - r2 IN: RO; synchronised pins.
  - r3 IFLAG: read; write-1-to-clear.
  - r4 IMASK: RW.
  - r5 IEDGE: RW; 1 = rising, 0 = falling.
  - r6 OUT_SET: write ORs data into OUT; reads 8'h00.
  - r7 OUT_CLR: write clears the set bits of OUT; reads 8'h00.
- Writes to r2 have no effect. Reads have no side effects.
- Input path per pin:
  - s1 <= pin_in; s2 <= s1; s3 <= s2.
  - IN = s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - event = IEDGE ? rise : fall.
- A flag is set on an event regardless of IMASK. If a W1C write and an event hit the same bit in the same cycle, set wins and the flag stays 1.
- Warm-up: a 2-bit counter starts at 0 on reset and saturates at 3. Events are ignored until the counter reads 3 (3 clocks after reset release), which prevents spurious flags from the reset values of s1–s3.
- irq <= |(IFLAG & IMASK) across all ports.
- Access on a cycle without bus_sel: ignored. Miss (offset ≥ 8*N_PORTS): no register change, bus_hit <= 0, bus_rdata holds its previous value.
- Reset (async, any time, including mid-access):
  - All registers, s1–s3, the warm-up counter, bus_rdata, bus_hit and irq go to 0.
  - Consequently pin_out = 0 and pin_oe = 0.

## Timing
- Write: the register updates on the clk edge that samples bus_sel=1. pin_out/pin_oe change on that same edge.
- Read: bus_rdata and bus_hit are valid from the edge that samples bus_sel=1 and hold until the next strobed hit. Read latency is 1 clk.
- Back-to-back strobes every cycle are supported. A read following a write to the same register returns the new value.
- Pin change is captured in s1 at edge k:
  - IN reflects it after edge k+1.
  - IFLAG sets at edge k+2.
  - irq asserts at edge k+3.
- Pulses shorter than one clk may be missed; no minimum beyond that is guaranteed.
- irq deasserts 1 clk after the W1C write or IMASK clear that removes the last pending masked flag.

## Test plan
- Reset: hold reset_n=0 with random pins, release, wait 10 clk without events -> all IFLAG = 0, irq = 0, pin_out = 0, pin_oe = 0. Repeat with reset_n pulsed low during a write to OUT -> OUT = 0.
- Register map, N_PORTS=2:
  - Write 8'hA5 to 16'h8400, 8'h0F to 16'h8401, 8'h3C to 16'h8408 -> pin_out = 16'h3CA5, pin_oe = 16'h000F.
  - Read back same values.
  - Access 16'h8410 -> bus_hit = 0, bus_rdata unchanged.
- Set/clear:
  - OUT=8'h00, write 8'h81 to OUT_SET -> 8'h81.
  - Write 8'h01 to OUT_CLR -> 8'h80.
  - Reads of r6/r7 -> 8'h00.
- Edge interrupt:
  - IMASK=8'h01, IEDGE=8'h01, pin0 0->1 captured at edge k -> IFLAG bit0 set at k+2, irq = 1 at k+3.
  - Falling edge on pin0 -> no new flag.
  - W1C 8'h01 -> irq = 0 one clk later.
- Collision: schedule the W1C of bit0 on the same edge a new rising event on pin0 is detected -> IFLAG bit0 remains 1 and irq stays 1.
- Masked flag: IMASK=0, toggle pin3 -> IFLAG bit3 = 1, irq = 0. Then write IMASK=8'h08 -> irq = 1 one clk later.
